wb_daq_channel_arbiter: RTL

//  Schedules the single DAQ bus master among NUM_CH acquisition channels. Picks a requesting

---
 rtl/wb_daq_channel_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_daq_channel_arbiter.sv
// wb_daq_channel_arbiter
//  Round-robin scheduler that hands the single DAQ bus master to one of
//  NUM_CH acquisition channels at a time. Each grant issues one fixed-length
//  burst at the channel's circular write pointer. The pointer advances only on
//  a clean burst completion.
//  Optional feature macro: DAQ_ARB_TIMEOUT_EN adds an XFER watchdog of TIMEOUT
//  cycles. When it expires, the burst is handled as a master error.
module wb_daq_channel_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned BUF_BYTES = 1024,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic                 enable_i,
    input  logic [NUM_CH-1:0]    chan_req_i,
    input  logic [NUM_CH*AW-1:0] chan_base_i,
    output logic [NUM_CH-1:0]    chan_grant_o,
    output logic [NUM_CH-1:0]    chan_pop_o,
    output logic [NUM_CH-1:0]    chan_wrap_o,
    output logic                 mst_start_o,
    output logic [AW-1:0]        mst_adr_o,
    output logic [7:0]           mst_len_o,
    input  logic                 mst_ack_i,
    input  logic                 mst_done_i,
    input  logic                 mst_err_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [2:0]           err_ch_o,
    input  logic                 err_clr_i
);

    localparam int unsigned IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned OW   = $clog2(BUF_BYTES);
    localparam int unsigned STEP = BURST_LEN * 4;

    // Reject parameter sets the pointer arithmetic cannot honour
    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT == 0 || BURST_LEN == 0 ||
        (BURST_LEN & (BURST_LEN - 1)) != 0 || (BUF_BYTES & (BUF_BYTES - 1)) != 0 ||
        (BUF_BYTES % STEP) != 0) begin : g_param_check
        $error("wb_daq_channel_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } state_e;

    state_e              state_q;
    logic [NUM_CH-1:0]   grant_q;
    logic [NUM_CH-1:0]   wrap_q;
    logic                start_q;
    logic [AW-1:0]       adr_q;
    logic [7:0]          len_q;
    logic                busy_q;
    logic                err_q;
    logic [2:0]          err_ch_q;
    logic [IW-1:0]       gidx_q;
    logic [IW-1:0]       last_q;
    logic [OW-1:0]       off_q [NUM_CH];

    logic                pick_vld;
    logic [IW-1:0]       pick_idx;
    int unsigned         cand;
    logic [AW-1:0]       base_sel;
    logic [OW-1:0]       off_sel;
    logic [OW-1:0]       off_nxt;
    logic                tmo_hit;

    // First requester after the last-served channel, wrapping around
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!pick_vld && chan_req_i[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    // Base address and write offset of the granted channel
    always_comb begin
        base_sel = '0;
        off_sel  = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (gidx_q == IW'(n)) begin
                base_sel = chan_base_i[n*AW +: AW];
                off_sel  = off_q[n];
            end
        end
        off_nxt = off_sel + OW'(STEP);
    end

`ifdef DAQ_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = (state_q == ST_XFER) && (tmo_q == TW'(TIMEOUT - 1));

    // XFER watchdog: cleared on START, counts every XFER cycle
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            tmo_q <= '0;
        end else if (state_q == ST_START) begin
            tmo_q <= '0;
        end else if (state_q == ST_XFER && !tmo_hit) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Pop follows the master's word ack directly; nothing pops while reset is held
    assign chan_pop_o = (wb_rst && state_q == ST_XFER && mst_ack_i) ? grant_q : '0;

    // Arbiter FSM with its registered outputs and per-channel pointers
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            wrap_q   <= '0;
            start_q  <= 1'b0;
            adr_q    <= '0;
            len_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
            gidx_q   <= '0;
            last_q   <= IW'(NUM_CH - 1);
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                off_q[n] <= '0;
            end
        end else begin
            start_q <= 1'b0;
            wrap_q  <= '0;
            len_q   <= 8'(BURST_LEN);
            if (err_clr_i) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && pick_vld) begin
                        grant_q <= NUM_CH'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    start_q <= 1'b1;
                    adr_q   <= base_sel + AW'(off_sel);
                    state_q <= ST_XFER;
                end
                ST_XFER: begin
                    if (mst_err_i || tmo_hit) begin
                        // Pointers untouched so the same channel is retried
                        err_q    <= 1'b1;
                        err_ch_q <= 3'(gidx_q);
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (mst_done_i) begin
                        off_q[gidx_q] <= off_nxt;
                        if (off_nxt == '0) begin
                            wrap_q <= grant_q;
                        end
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign chan_grant_o = grant_q;
    assign chan_wrap_o  = wrap_q;
    assign mst_start_o  = start_q;
    assign mst_adr_o    = adr_q;
    assign mst_len_o    = len_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign err_ch_o     = err_ch_q;

endmodule
